// File: rtl/pmem_arbiter.sv
// pmem_arbiter: one-transaction-at-a-time N-channel arbiter onto the pmem port.
// Round-robin by default; define PMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest channel wins).
module pmem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    localparam int ID_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [ID_W-1:0]          grant_id,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state;
    logic [NUM_CH-1:0] req;
    logic [ID_W-1:0] win;
`ifndef PMEM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] last_grant;
`endif
    assign req = ch_read | ch_write;
    always_comb begin
        win = '0;
`ifdef PMEM_ARB_FIXED_PRIO_EN
        for (int i = NUM_CH - 1; i >= 0; i--) if (req[i]) win = ID_W'(i);
`else
        // scan farthest-first so the nearest requester after last_grant overwrites the rest
        for (int i = NUM_CH; i >= 1; i--)
            if (req[(int'(last_grant) + i) % NUM_CH]) win = ID_W'((int'(last_grant) + i) % NUM_CH);
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            ch_rdata     <= '0;
            ch_resp      <= '0;
            grant_id     <= '0;
`ifndef PMEM_ARB_FIXED_PRIO_EN
            last_grant   <= ID_W'(NUM_CH - 1);
`endif
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state        <= ISSUE;
                    grant_id     <= win;
`ifndef PMEM_ARB_FIXED_PRIO_EN
                    last_grant   <= win;
`endif
                    pmem_read    <= ch_read[win] & ~ch_write[win];
                    pmem_write   <= ch_write[win];
                    pmem_address <= ch_address[win*ADDR_W +: ADDR_W];
                    pmem_wdata   <= ch_wdata[win*LINE_W +: LINE_W];
                end
                ISSUE: if (pmem_resp) begin
                    state      <= RESP;
                    ch_rdata   <= pmem_read ? pmem_rdata : ch_rdata;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    ch_resp    <= NUM_CH'(1) << grant_id;
                end
                RESP: begin
                    state   <= IDLE;
                    ch_resp <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: randomized requesters checked against a transaction-level arbitration model.
module tb_pmem_arbiter;
    localparam int N = 4;
    localparam int LW = 64;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] ch_read = '0, ch_write = '0;
    logic [N*AW-1:0] ch_address = '0;
    logic [N*LW-1:0] ch_wdata = '0;
    logic [LW-1:0] ch_rdata;
    logic [N-1:0] ch_resp;
    logic [1:0] grant_id;
    logic pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic pmem_resp = 1'b0;

    always #5 clk = ~clk;

    pmem_arbiter #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
        .ch_resp(ch_resp), .grant_id(grant_id), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    bit pend[N], prd[N], pwr[N];
    logic [AW-1:0] paddr[N];
    logic [LW-1:0] pwd[N];
    int last = N - 1;
    logic [LW-1:0] exp_rdata = '0;
    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ch_read[i] = pend[i] & prd[i];
            ch_write[i] = pend[i] & pwr[i];
            ch_address[i*AW +: AW] = paddr[i];
            ch_wdata[i*LW +: LW] = pwd[i];
        end
    endtask

    task automatic post(input int c, input bit r, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        pend[c] = 1'b1; prd[c] = r; pwr[c] = w; paddr[c] = a; pwd[c] = d;
        drive();
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom};
    endfunction

    task automatic post_rand(input int c);
        int op = $urandom_range(0, 4);
        post(c, op != 2 && op != 3, op >= 2, $urandom, rnd_line());
    endtask

    task automatic rand_posts();
        for (int c = 0; c < N; c++) if (!pend[c] && $urandom_range(0, 2) == 0) post_rand(c);
    endtask

    function automatic int pick();
`ifdef PMEM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < N; c++) if (pend[c]) return c;
`else
        for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called during an IDLE cycle with at least one request pending
    task automatic run_txn(input int lat, input bit churn, input logic [LW-1:0] rdata);
        int w = pick();
        bit rd = prd[w] && !pwr[w];
        tick();
        check("grant_id", grant_id, w);
        check("pmem_read", pmem_read, rd);
        check("pmem_write", pmem_write, pwr[w]);
        check("pmem_address", pmem_address, paddr[w]);
        if (pwr[w]) check("pmem_wdata", pmem_wdata, pwd[w]);
        check("resp_issue", ch_resp, 0);
        pmem_resp = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (churn) rand_posts();
            tick();
            check("hold", {pmem_read, pmem_write}, {rd, pwr[w]});
        end
        pmem_resp = 1'b1;
        pmem_rdata = rdata;
        tick();
        if (rd) exp_rdata = rdata;
        check("ch_resp", ch_resp, 64'd1 << w);
        check("ch_rdata", ch_rdata, exp_rdata);
        check("drop_op", {pmem_read, pmem_write}, 0);
        pend[w] = 1'b0;
        drive();
        last = w;
        pmem_resp = 1'($urandom_range(0, 1));
        pmem_rdata = rnd_line();
        tick();
        pmem_resp = 1'b0;
        check("resp_pulse", ch_resp, 0);
        check("rdata_keep", ch_rdata, exp_rdata);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin pend[c] = 0; prd[c] = 0; pwr[c] = 0; paddr[c] = '0; pwd[c] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", pmem_read, 0);
        check("rst_write", pmem_write, 0);
        check("rst_addr", pmem_address, 0);
        check("rst_wdata", pmem_wdata, 0);
        check("rst_rdata", ch_rdata, 0);
        check("rst_resp", ch_resp, 0);
        check("rst_grant", grant_id, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        pmem_resp = 1'b1;
        pmem_rdata = rnd_line();
        tick();
        pmem_resp = 1'b0;
        check("idle_resp_ign", ch_resp, 0);
        check("idle_rdata_ign", ch_rdata, 0);
        check("idle_no_op", {pmem_read, pmem_write}, 0);

        post(1, 1, 0, 32'h0000_1000, '0);
        run_txn(4, 0, {8{8'hA5}});
        check("read_a5", ch_rdata, {8{8'hA5}});
        post(0, 0, 1, 32'h40, 64'h1234_5678_9abc_def0);
        run_txn(2, 0, rnd_line());
        post(2, 1, 1, 32'h80, rnd_line());
        run_txn(1, 0, rnd_line());

        post(2, 1, 0, 32'h200, '0);
        tick();
        check("pre_rst_read", pmem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_read", pmem_read, 0);
        check("async_addr", pmem_address, 0);
        check("async_grant", grant_id, 0);
        tick();
        check("rst_no_resp", ch_resp, 0);
        last = N - 1;
        exp_rdata = '0;
        for (int c = 0; c < N; c++) if (!pend[c]) post_rand(c);
        @(negedge clk) rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            run_txn($urandom_range(0, 3), 0, rnd_line());
`ifdef PMEM_ARB_FIXED_PRIO_EN
            check("prio_order", grant_id, 0);
`else
            check("rr_order", grant_id, t % N);
`endif
            post_rand(int'(grant_id));
        end

        for (int t = 0; t < 150; t++) begin
            if (pick() < 0) post_rand($urandom_range(0, N - 1));
            rand_posts();
            run_txn($urandom_range(0, 3), 1, rnd_line());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
